// File: rtl/adder_bist_ctrl.sv
// ---------------------------------------------------------------------------
// adder_bist_ctrl
//   Built-in self-test sequencer for an external WIDTH-bit adder under test
//   (AUT). Sweeps every {A,B} pair in index order, one vector per clock. It
//   compares the AUT sum against an internal golden add, counts mismatching
//   vectors and captures the first failing vector.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          begin a sweep; honoured only in IDLE or DONE
//   op_a, op_b     registered operands driven to the AUT
//   sum_in         AUT result (WIDTH+1 bits), LAT clocks behind op_a/op_b
//   busy           sweep or drain in progress
//   done           results valid; held until the next start
//   pass           done with zero mismatches
//   err_count      number of mismatching vectors
//   fail_valid     first_fail_* hold a captured vector
//   first_fail_a   A of the first mismatch
//   first_fail_b   B of the first mismatch
//   first_fail_sum AUT sum observed at the first mismatch
//   dbg_state      current FSM state (0 IDLE, 1 SWEEP, 2 DRAIN, 3 DONE)
//
// Handshake: start is a level sampled on each rising edge; it is acted on
// only in IDLE or DONE and ignored while busy. No ready/valid back-pressure
// exists: the AUT must accept one vector per clock.
// ---------------------------------------------------------------------------
module adder_bist_ctrl #(
    parameter int WIDTH = 4,
    parameter int LAT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH:0]     sum_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b,
    output logic [WIDTH:0]     first_fail_sum,
    output logic [1:0]         dbg_state
);

    localparam int VW     = 2 * WIDTH;
    localparam int DCW    = (LAT < 2) ? 1 : $clog2(LAT);
    localparam int LAT_M1 = (LAT > 0) ? LAT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q;
    logic [DCW-1:0]  drain_q;
    logic            last_vec;
    logic            start_ok;
    logic [WIDTH:0]  gold_now;

    // Compare-slot view: the vector whose AUT result is on sum_in this cycle.
    logic            cmp_v;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic [WIDTH:0]  cmp_g;

    assign last_vec = (vec_q == {VW{1'b1}});
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign gold_now = {1'b0, op_a} + {1'b0, op_b};

    // Operands are the sweep index itself; it reads 0 outside SWEEP.
    assign op_a = vec_q[VW-1:WIDTH];
    assign op_b = vec_q[WIDTH-1:0];

    assign busy      = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_count == '0);
    assign dbg_state = state_q;

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SWEEP;
            // With a combinational AUT the last vector is compared on the
            // edge that leaves SWEEP, so there is nothing left to drain.
            S_SWEEP: if (last_vec) state_d = (LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_q == DCW'(LAT_M1)) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_SWEEP;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ index / drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q   <= '0;
            drain_q <= '0;
        end else begin
            if (state_q == S_SWEEP) vec_q <= last_vec ? '0 : vec_q + 1'b1;
            else                    vec_q <= '0;
            if (state_q == S_DRAIN) drain_q <= drain_q + 1'b1;
            else                    drain_q <= '0;
        end
    end

    // ------------------------------------------------------------ delay line
    generate
        if (LAT == 0) begin : g_comb
            assign cmp_v = (state_q == S_SWEEP);
            assign cmp_a = op_a;
            assign cmp_b = op_b;
            assign cmp_g = gold_now;
        end else begin : g_pipe
            logic             dl_v [LAT];
            logic [WIDTH-1:0] dl_a [LAT];
            logic [WIDTH-1:0] dl_b [LAT];
            logic [WIDTH:0]   dl_g [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        dl_v[i] <= 1'b0;
                        dl_a[i] <= '0;
                        dl_b[i] <= '0;
                        dl_g[i] <= '0;
                    end
                end else begin
                    dl_v[0] <= (state_q == S_SWEEP);
                    dl_a[0] <= op_a;
                    dl_b[0] <= op_b;
                    dl_g[0] <= gold_now;
                    for (int i = 1; i < LAT; i++) begin
                        dl_v[i] <= dl_v[i-1];
                        dl_a[i] <= dl_a[i-1];
                        dl_b[i] <= dl_b[i-1];
                        dl_g[i] <= dl_g[i-1];
                    end
                end
            end

            assign cmp_v = dl_v[LAT-1];
            assign cmp_a = dl_a[LAT-1];
            assign cmp_b = dl_b[LAT-1];
            assign cmp_g = dl_g[LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------ results
    // start never coincides with a valid compare: compares are only pending
    // in SWEEP/DRAIN, where start is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_sum <= '0;
        end else if (start_ok) begin
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_sum <= '0;
        end else if (cmp_v && (sum_in != cmp_g)) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
                fail_valid     <= 1'b1;
                first_fail_a   <= cmp_a;
                first_fail_b   <= cmp_b;
                first_fail_sum <= sum_in;
            end
        end
    end

endmodule
